mul_arbiter: RTL and testbench

Round-robin arbiter sharing one `mul_clocked` multiplier between `num_clients` requesters (e.g. several cores or pipeline stages). Each client issues a one-cycle request pulse with operands. The arbiter buffers the operands per client, issues one multiply at a time to the shared multiplier using the multiplier's own req/ack pulse protocol, and returns the product on a shared result bus with a per-client ack pulse. The block sits between the clients and a single `mul_clocked` instance; it does no arithmetic itself.

---
 rtl/mul_arbiter.sv | 134 +++++++++++++
 tb/tb_mul_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one req/ack pulse multiplier between
// num_clients requesters, buffering one operand pair per client.
module mul_arbiter #(
  parameter int num_clients = 4,
  parameter int width       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [num_clients-1:0]         cli_req,
  input  logic [num_clients*width-1:0]   cli_a,
  input  logic [num_clients*width-1:0]   cli_b,
  output logic [num_clients-1:0]         cli_ack,
  output logic [width-1:0]               cli_out,
  output logic                           mul_req,
  output logic [width-1:0]               mul_a,
  output logic [width-1:0]               mul_b,
  input  logic                           mul_ack,
  input  logic [width-1:0]               mul_out
);

  localparam int IDX_W = $clog2(num_clients);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(num_clients - 1);

  logic [1:0]             r_state;
  logic [num_clients-1:0] r_pending;
  logic [width-1:0]       r_a_q [num_clients];
  logic [width-1:0]       r_b_q [num_clients];
  logic [IDX_W-1:0]       r_sel;
  logic [IDX_W-1:0]       r_last;
  logic [num_clients-1:0] r_cli_ack;
  logic [width-1:0]       r_cli_out;
  logic                   r_mul_req;
  logic [width-1:0]       r_mul_a;
  logic [width-1:0]       r_mul_b;

  logic [num_clients-1:0] w_sel_oh;
  logic [num_clients-1:0] w_clear;
  logic [num_clients-1:0] w_accept;
  logic [IDX_W-1:0]       w_cand [num_clients];
  logic [IDX_W-1:0]       w_sel;
  logic                   w_found;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[r_sel] = 1'b1;
    w_clear         = (r_state == S_DONE) ? w_sel_oh : '0;
    // A re-request in the ack cycle is accepted: set wins over clear.
    w_accept        = cli_req & (~r_pending | w_clear);
  end

  // Search upward from last+1 (modulo num_clients) for the first pending client.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    for (int k = 0; k < num_clients; k++) begin
      w_cand[k] = IDX_W'((int'(r_last) + k + 1) % num_clients);
    end
    for (int k = 0; k < num_clients; k++) begin
      if (!w_found && r_pending[w_cand[k]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[k];
      end
    end
  end

  // NOTE: operand storage has no reset; its contents are only read while the matching pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < num_clients; i++) begin
      if (w_accept[i]) begin
        r_a_q[i] <= cli_a[i*width +: width];
        r_b_q[i] <= cli_b[i*width +: width];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_sel     <= '0;
      r_last    <= LAST_RST;
      r_cli_ack <= '0;
      r_cli_out <= '0;
      r_mul_req <= 1'b0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_accept;
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_sel     <= w_sel;
            r_mul_req <= 1'b1;
            r_mul_a   <= r_a_q[w_sel];
            r_mul_b   <= r_b_q[w_sel];
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mul_req <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_ack) begin
            r_cli_out <= mul_out;
            r_cli_ack <= w_sel_oh;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_cli_ack <= '0;
          r_last    <= r_sel;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cli_ack = r_cli_ack;
  assign cli_out = r_cli_out;
  assign mul_req = r_mul_req;
  assign mul_a   = r_mul_a;
  assign mul_b   = r_mul_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a behavioural multiplier responder plus a cycle-level
// reference model of the arbitration rules, driven by directed and random traffic.
module tb_mul_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   cli_req = '0;
  logic [N*W-1:0] cli_a = '0;
  logic [N*W-1:0] cli_b = '0;
  logic [N-1:0]   cli_ack;
  logic [W-1:0]   cli_out;
  logic           mul_req;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_ack = 1'b0;
  logic [W-1:0]   mul_out = '0;

  mul_arbiter #(.num_clients(N), .width(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .cli_req (cli_req),
    .cli_a   (cli_a),
    .cli_b   (cli_b),
    .cli_ack (cli_ack),
    .cli_out (cli_out),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
    .mul_out (mul_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state: what is buffered per client, who was served last,
  // and the one transaction in flight.
  logic [N-1:0] m_pend, m_pp;
  logic [W-1:0] m_pa [N];
  logic [W-1:0] m_pb [N];
  logic [W-1:0] m_ia, m_ib, m_prod;
  int           m_last = N - 1;
  int           m_g = 0;
  int           m_ack_at = -1;
  bit           m_inflight = 0;
  bit           m_bp = 0;
  bit           exp_req;
  logic [N-1:0] exp_ack;
  int           lat_min = 1;
  int           lat_max = 4;
  int           n_req = 0;

  typedef struct {
    logic [N-1:0] ack;
    logic [W-1:0] out;
  } obs_t;
  obs_t obs[$];

  logic [W-1:0] re_a [N];
  logic [W-1:0] re_b [N];

  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  // Multiplier responder: ack exactly at the cycle chosen when the request was seen.
  always @(posedge clk) begin
    #1;
    if (rst && m_inflight && cyc == m_ack_at) begin
      mul_ack = 1'b1;
      mul_out = m_prod;
    end else begin
      mul_ack = 1'b0;
      mul_out = $urandom;
    end
  end

  // Observe the current cycle's outputs, compare, then apply this cycle's edge to the model.
  always @(negedge clk) begin
    if (!rst) begin
      m_pend     = '0;
      m_pp       = '0;
      m_bp       = 0;
      m_inflight = 0;
      m_last     = N - 1;
      m_ack_at   = -1;
    end else begin
      // The multiplier is free and something was pending one cycle ago -> issue now.
      exp_req = !m_bp && (m_pp != '0);
      check("mul_req", mul_req, exp_req);
      if (mul_req) n_req++;
      if (exp_req) begin
        m_g        = rr_pick(m_pp, m_last);
        m_ia       = m_pa[m_g];
        m_ib       = m_pb[m_g];
        m_prod     = m_ia * m_ib;
        m_ack_at   = cyc + int'($urandom_range(lat_max, lat_min));
        m_inflight = 1;
      end
      if (m_inflight && cyc <= m_ack_at) begin
        check("mul_a", mul_a, m_ia);
        check("mul_b", mul_b, m_ib);
      end
      exp_ack = '0;
      if (m_inflight && cyc == m_ack_at + 1) exp_ack[m_g] = 1'b1;
      check("cli_ack", cli_ack, exp_ack);
      if (exp_ack != '0) check("cli_out", cli_out, m_prod);
      if (cli_ack != '0) obs.push_back('{cli_ack, cli_out});
      m_pp = m_pend;
      m_bp = m_inflight;
      if (exp_ack != '0) begin
        m_pend[m_g] = 1'b0;
        m_last      = m_g;
        m_inflight  = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (cli_req[i] && !m_pend[i]) begin
          m_pend[i] = 1'b1;
          m_pa[i]   = cli_a[i*W +: W];
          m_pb[i]   = cli_b[i*W +: W];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cli_req = '0;
  endtask

  task automatic post(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    cli_req[c]      = 1'b1;
    cli_a[c*W +: W] = a;
    cli_b[c*W +: W] = b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst     = 1'b0;
    cli_req = '0;
    #1;
    check("rst cli_ack", cli_ack, 0);
    check("rst cli_out", cli_out, 0);
    check("rst mul_req", mul_req, 0);
    check("rst mul_a", mul_a, 0);
    check("rst mul_b", mul_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    obs.delete();
    n_req = 0;
  endtask

  // Clients in mask re-request with re_a/re_b in the very cycle of their ack.
  task automatic wait_acks(input int n, input logic [N-1:0] mask);
    int budget;
    budget = 0;
    while (obs.size() < n && budget < 400) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (cli_ack[i] && mask[i]) post(i, re_a[i], re_b[i]);
      end
      budget++;
    end
    if (obs.size() < n) check("ack timeout", obs.size(), n);
  endtask

  task automatic check_obs(input int k, input logic [N-1:0] ack, input logic [W-1:0] out);
    if (k < obs.size()) begin
      check($sformatf("result%0d client", k), obs[k].ack, ack);
      check($sformatf("result%0d value", k), obs[k].out, out);
    end else begin
      check($sformatf("result%0d present", k), obs.size(), k + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      re_a[i] = 32'd7;
      re_b[i] = 32'(9 + i);
    end

    // Single client.
    do_reset();
    post(0, 32'd3, 32'd5);
    wait_acks(1, '0);
    check_obs(0, 4'b0001, 32'd15);

    // Simultaneous requests from clients 1 and 2.
    do_reset();
    post(1, 32'd15, 32'd4);
    post(2, 32'd347911, 32'd12345);
    wait_acks(2, '0);
    repeat (6) tick();
    check_obs(0, 4'b0010, 32'd60);
    check_obs(1, 4'b0100, 32'd4294961295);
    check("mul_req pulses", n_req, 2);

    // Fairness: every client re-requests at each ack.
    do_reset();
    for (int i = 0; i < N; i++) post(i, re_a[i], re_b[i]);
    wait_acks(12, 4'b1111);
    for (int k = 0; k < 12; k++) check_obs(k, 4'(1 << (k % N)), 32'(7 * (9 + k % N)));

    // Busy buffering, dropped duplicate, and re-request in the ack cycle.
    do_reset();
    lat_min = 4;
    lat_max = 4;
    post(0, 32'd3, 32'd5);
    repeat (3) tick();
    post(3, 32'd9556, 32'd124);
    tick();
    post(3, 32'd1, 32'd1);
    re_a[3] = 32'd0;
    re_b[3] = 32'd7;
    wait_acks(3, 4'b1000);
    check_obs(0, 4'b0001, 32'd15);
    check_obs(1, 4'b1000, 32'd1184944);
    check_obs(2, 4'b1000, 32'd0);

    // Reset during WAIT loses the request.
    do_reset();
    post(2, 32'd1254424, 32'd124);
    repeat (3) tick();
    do_reset();
    post(2, 32'd3, 32'd5);
    wait_acks(1, '0);
    repeat (10) tick();
    check("results after reset", obs.size(), 1);
    check_obs(0, 4'b0100, 32'd15);

    // Random traffic with random multiplier latency, duplicates included.
    lat_min = 1;
    lat_max = 4;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3, 0) == 0) post(i, $urandom, $urandom);
      end
    end
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
